// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, key-schedule state, round constants
// and GF(2^8) helpers used by the key expander and the S-box.
package aes_pkg;

   localparam logic [3:0] AES_ROUNDS_128 = 4'd10;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } ks_state_e;

   // Round constant applied when deriving round key idx+1 from round key idx.
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd0:    return 8'h01;
         4'd1:    return 8'h02;
         4'd2:    return 8'h04;
         4'd3:    return 8'h08;
         4'd4:    return 8'h10;
         4'd5:    return 8'h20;
         4'd6:    return 8'h40;
         4'd7:    return 8'h80;
         4'd8:    return 8'h1b;
         4'd9:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // Cyclic left rotate of a word by one byte.
   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // Ripple the mixed word t through the four words of the previous round key.
   function automatic logic [127:0] chain_xor(input logic [127:0] key, input logic [31:0] t);
      logic [31:0] w0, w1, w2, w3;
      w0 = key[127:96] ^ t;
      w1 = key[95:64]  ^ w0;
      w2 = key[63:32]  ^ w1;
      w3 = key[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = gf_xtime(aa);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0).
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = x;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   // S-box affine transform over the inverted byte.
   function automatic logic [7:0] sbox_affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, either as a constant table or as inverse+affine logic.
module aes_sbox
   import aes_pkg::*;
#(
   parameter string IMPL = "LUT"
) (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   if (IMPL == "LOGIC") begin : gen_logic
      assign out_byte = sbox_affine(gf_inv(in_byte));
   end else begin : gen_lut
      localparam logic [0:255][7:0] SBOX_TABLE = {
         128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
         128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
         128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
         128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
         128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
         128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
         128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
         128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
      };
      assign out_byte = SBOX_TABLE[in_byte];
   end

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-boxes, one per byte of the word.
module aes_sub_word #(
   parameter string IMPL = "LUT"
) (
   input  logic [31:0] word_in,
   output logic [31:0] word_out
);

   for (genvar b = 0; b < 4; b++) begin : gen_sbox
      aes_sbox #(.IMPL(IMPL)) u_sbox (
         .in_byte  (word_in[8*b +: 8]),
         .out_byte (word_out[8*b +: 8])
      );
   end

endmodule

// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule: loads a cipher key on start and streams
// round keys 0..10 over a valid/ready interface, one per accepted beat.
module aes128_key_expand
   import aes_pkg::*;
#(
   parameter string SBOX_IMPL = "LUT"
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         rk_ready,
   output logic         rk_valid,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_index,
   output logic         busy,
   output logic         done
);

   ks_state_e    state_q, state_d;
   logic [127:0] rk_data_q, rk_data_d;
   logic [3:0]   rk_index_q, rk_index_d;
   logic         done_q, done_d;

   logic [31:0]  rot_w;
   logic [31:0]  sub_w;
   logic [127:0] next_key;

   assign rot_w = rot_word(rk_data_q[31:0]);

   aes_sub_word #(.IMPL(SBOX_IMPL)) u_sub_word (
      .word_in  (rot_w),
      .word_out (sub_w)
   );

   // Next round key, derived combinationally from the key currently on the output.
   always_comb begin
      next_key = chain_xor(rk_data_q, sub_w ^ {rcon(rk_index_q), 24'h000000});
   end

   // Next-state logic: load on start, advance on each accepted beat, finish after key 10.
   always_comb begin
      // NOTE: every target gets a default first so no path leaves a latch behind.
      state_d    = state_q;
      rk_data_d  = rk_data_q;
      rk_index_d = rk_index_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = EMIT;
               rk_data_d  = key_in;
               rk_index_d = 4'd0;
            end
         end
         EMIT: begin
            if (rk_ready) begin
               if (rk_index_q == AES_ROUNDS_128) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  rk_data_d  = next_key;
                  rk_index_d = rk_index_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, round-key and done-pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rk_data_q  <= '0;
         rk_index_q <= 4'd0;
         done_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q    <= state_d;
         rk_data_q  <= rk_data_d;
         rk_index_q <= rk_index_d;
         done_q     <= done_d;
      end
   end

   assign rk_valid = (state_q == EMIT);
   assign busy     = (state_q == EMIT);
   assign rk_data  = rk_data_q;
   assign rk_index = rk_index_q;
   assign done     = done_q;

endmodule

// File: tb/tb_aes128_key_expand.sv
// Bench for aes128_key_expand: drives a LUT-based and a logic-based instance
// with the same stimulus and compares both against a FIPS-197 word-array model.
module tb_aes128_key_expand;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [127:0] key_in;
   logic         rk_ready;

   logic         lut_valid, lut_busy, lut_done;
   logic [127:0] lut_data;
   logic [3:0]   lut_index;
   logic         log_valid, log_busy, log_done;
   logic [127:0] log_data;
   logic [3:0]   log_index;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]   sbox_tab [256];
   logic [127:0] model_rk [11];
   logic [127:0] got      [11];

   aes128_key_expand #(.SBOX_IMPL("LUT")) u_lut (
      .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .rk_ready(rk_ready),
      .rk_valid(lut_valid), .rk_data(lut_data), .rk_index(lut_index),
      .busy(lut_busy), .done(lut_done)
   );

   aes128_key_expand #(.SBOX_IMPL("LOGIC")) u_logic (
      .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .rk_ready(rk_ready),
      .rk_valid(log_valid), .rk_data(log_data), .rk_index(log_index),
      .busy(log_busy), .done(log_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] prod;
      logic [15:0] poly;
      prod = 16'h0000;
      for (int i = 0; i < 8; i++)
         if (b[i]) prod = prod ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) begin
         poly = 16'h011b << (i - 8);
         if (prod[i]) prod = prod ^ poly;
      end
      return prod[7:0];
   endfunction

   // S-box from its definition: inverse by exhaustive search, then the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] c;
      logic [7:0] s;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sbox_tab[x] = s;
      end
   endtask

   // Classic 44-word expansion, then regrouped into 11 round keys.
   task automatic build_model(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]}
                  ^ {rc, 24'h000000};
            rc  = m_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic check(input string tag, input logic [134:0] obs, input logic [134:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Tuple layout: {valid, busy, done, index, data}.
   task automatic check_both(input string tag, input logic [134:0] exp);
      check({tag, " lut"},   {lut_valid, lut_busy, lut_done, lut_index, lut_data}, exp);
      check({tag, " logic"}, {log_valid, log_busy, log_done, log_index, log_data}, exp);
   endtask

   function automatic logic [127:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One schedule. Called at posedge+1 with the DUT idle (or already loaded when skip_start).
   task automatic run(input string name, input logic [127:0] key, input bit rand_ready,
                      input int inject_beat, input int reset_beat, input bit chain, input bit skip_start);
      int idx;
      int cyc;
      build_model(key);
      if (!skip_start) begin
         start  = 1'b1;
         key_in = key;
         @(posedge clk); #1;
         start  = 1'b0;
         key_in = rand_key();
      end
      idx = 0;
      cyc = 0;
      while (idx <= 10 && cyc < 500) begin
         if (idx == reset_beat) begin
            rst_n = 1'b0;
            #1;
            check_both($sformatf("%s async reset", name), 135'd0);
            @(posedge clk); #1;
            check_both($sformatf("%s held in reset", name), 135'd0);
            rst_n = 1'b1;
            @(posedge clk); #1;
            check_both($sformatf("%s after reset no done", name), 135'd0);
            return;
         end
         check_both($sformatf("%s key%0d", name, idx), {1'b1, 1'b1, 1'b0, 4'(idx), model_rk[idx]});
         rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (idx == inject_beat) begin
            start  = 1'b1;
            key_in = rand_key();
         end
         if (rk_ready) got[idx] = lut_data;
         @(posedge clk); #1;
         start = 1'b0;
         if (rk_ready) idx++;
         cyc++;
      end
      n_checks++;
      assert (idx > 10) else begin
         n_fail++;
         $error("FAIL %s timeout: beats accepted %0d expected 11", name, idx);
      end
      rk_ready = 1'($urandom_range(0, 1));
      check_both($sformatf("%s done pulse", name), {1'b0, 1'b0, 1'b1, 4'd10, model_rk[10]});
      if (chain) begin
         start  = 1'b1;
         key_in = 128'd0;
      end
      @(posedge clk); #1;
      start  = 1'b0;
      key_in = rand_key();
      if (!chain)
         check_both($sformatf("%s idle after done", name), {1'b0, 1'b0, 1'b0, 4'd10, model_rk[10]});
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      key_in   = '0;
      rk_ready = 1'b0;
      build_sbox();
      @(posedge clk); #1;
      check_both("reset state", 135'd0);
      start  = 1'b1;
      key_in = rand_key();
      @(posedge clk); #1;
      check_both("start ignored in reset", 135'd0);
      start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_both("idle after reset", 135'd0);

      // FIPS-197 A.1 key, no backpressure.
      run("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, -1, -1, 1'b0, 1'b0);
      check("fips key1 const", {7'd0, got[1]}, {7'd0, 128'ha0fafe1788542cb123a339392a6c7605});
      check("fips key10 const", {7'd0, got[10]}, {7'd0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});

      // All-zero key.
      run("zero", 128'd0, 1'b0, -1, -1, 1'b0, 1'b0);
      check("zero key1 const", {7'd0, got[1]}, {7'd0, 128'h62636363626363636263636362636363});
      check("zero key10 const", {7'd0, got[10]}, {7'd0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e});

      // Random backpressure; stalled beats must hold data and index.
      run("fips_bp", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, -1, -1, 1'b0, 1'b0);

      // Start with a new key mid-schedule must be ignored.
      run("fips_restart", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 4, -1, 1'b0, 1'b0);
      check("restart key10 const", {7'd0, got[10]}, {7'd0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});

      // Asynchronous reset at round key 5, then a clean schedule.
      run("fips_rst", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, -1, 5, 1'b0, 1'b0);
      run("post_rst", rand_key(), 1'b1, -1, -1, 1'b0, 1'b0);

      // Start in the done cycle chains straight into a zero-key schedule.
      run("chain_a", rand_key(), 1'b1, -1, -1, 1'b1, 1'b0);
      run("chain_zero", 128'd0, 1'b0, -1, -1, 1'b0, 1'b1);

      // Random keys under random backpressure.
      for (int k = 0; k < 3; k++)
         run($sformatf("rand%0d", k), rand_key(), 1'b1, -1, -1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
